// File: rtl/random_lfsr_gen.sv
// Pseudo-random source for the 2048 game: free-running Galois LFSR with a
// seed-load path and a req/valid handshake that rejection-samples against a limit.
module random_lfsr_gen #(
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'h0001,
    parameter int                NUM_CH       = 2,
    parameter int                OUT_W        = 4,
    parameter int                MAX_TRIES    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed_in,
    input  logic                    req,
    input  logic [OUT_W-1:0]        limit,
    output logic                    busy,
    output logic                    valid,
    output logic                    timeout,
    output logic [NUM_CH*OUT_W-1:0] out_bus,
    output logic [LFSR_W-1:0]       lfsr_state
);

    localparam int BUS_W = NUM_CH * OUT_W;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic {
        IDLE,
        DRAW
    } fsm_t;

    fsm_t              fsm, fsm_nxt;
    logic [LFSR_W-1:0] lfsr, lfsr_nxt;
    logic [OUT_W-1:0]  limit_q, limit_nxt;
    logic [TRY_W-1:0]  tries, tries_nxt;
    logic [BUS_W-1:0]  out_q, out_nxt;
    logic              valid_q, valid_nxt;
    logic              timeout_q, timeout_nxt;
    logic [BUS_W-1:0]  cand;
    logic [BUS_W-1:0]  forced;
    logic [NUM_CH-1:0] ch_ok;

    // An all-zero state would lock the LFSR, so it is replaced by the default seed.
    always_comb begin
        lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        if (lfsr == '0)
            lfsr_nxt = SEED_DEFAULT;
        if (seed_load)
            lfsr_nxt = (seed_in == '0) ? SEED_DEFAULT : seed_in;
    end

    // Channels take interleaved state bits so neighbouring channels decorrelate.
    always_comb begin
        cand = '0;
        for (int c = 0; c < NUM_CH; c++)
            for (int b = 0; b < OUT_W; b++)
                cand[c*OUT_W + b] = lfsr[b*NUM_CH + c];
    end

    always_comb begin
        ch_ok  = '0;
        forced = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_ok[c] = (limit_q == '0) || (cand[c*OUT_W +: OUT_W] < limit_q);
            forced[c*OUT_W +: OUT_W] = ch_ok[c] ? cand[c*OUT_W +: OUT_W] : '0;
        end
    end

    always_comb begin
        fsm_nxt     = fsm;
        limit_nxt   = limit_q;
        tries_nxt   = tries;
        out_nxt     = out_q;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        case (fsm)
            IDLE: begin
                if (req) begin
                    limit_nxt = limit;
                    tries_nxt = '0;
                    fsm_nxt   = DRAW;
                end
            end
            DRAW: begin
                if (&ch_ok) begin
                    out_nxt   = cand;
                    valid_nxt = 1'b1;
                    fsm_nxt   = IDLE;
                end else if (tries == LAST_TRY) begin
                    out_nxt     = forced;
                    valid_nxt   = 1'b1;
                    timeout_nxt = 1'b1;
                    fsm_nxt     = IDLE;
                end else begin
                    tries_nxt = tries + 1'b1;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr      <= SEED_DEFAULT;
            fsm       <= IDLE;
            limit_q   <= '0;
            tries     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            lfsr      <= lfsr_nxt;
            fsm       <= fsm_nxt;
            limit_q   <= limit_nxt;
            tries     <= tries_nxt;
            out_q     <= out_nxt;
            valid_q   <= valid_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign busy       = (fsm == DRAW);
    assign valid      = valid_q;
    assign timeout    = timeout_q;
    assign out_bus    = out_q;
    assign lfsr_state = lfsr;

endmodule

// File: tb/tb_random_lfsr_gen.sv
// Directed bench for random_lfsr_gen: instance 0 uses defaults, instance 1 has
// MAX_TRIES=4 so forced completions can be reached with hand-picked seeds.
module tb_random_lfsr_gen;

    logic        clk;
    logic        reset;
    logic        seed_load [2];
    logic [15:0] seed_in   [2];
    logic        req       [2];
    logic [3:0]  limit     [2];

    logic        busy0, valid0, timeout0;
    logic [7:0]  out0;
    logic [15:0] state0;
    logic        busy1, valid1, timeout1;
    logic [7:0]  out1;
    logic [15:0] state1;

    int n_checks;
    int n_fail;

    random_lfsr_gen dut (
        .clk(clk), .reset(reset), .seed_load(seed_load[0]), .seed_in(seed_in[0]),
        .req(req[0]), .limit(limit[0]), .busy(busy0), .valid(valid0),
        .timeout(timeout0), .out_bus(out0), .lfsr_state(state0)
    );

    random_lfsr_gen #(.MAX_TRIES(4)) dut_t (
        .clk(clk), .reset(reset), .seed_load(seed_load[1]), .seed_in(seed_in[1]),
        .req(req[1]), .limit(limit[1]), .busy(busy1), .valid(valid1),
        .timeout(timeout1), .out_bus(out1), .lfsr_state(state1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        if (s == 16'h0000)
            return 16'h0001;
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [7:0] ref_cand(input logic [15:0] s);
        return {s[7], s[5], s[3], s[1], s[6], s[4], s[2], s[0]};
    endfunction

    // Reference draw: the candidate at evaluation edge i comes from step^i(seed).
    task automatic ref_draw(input logic [15:0] seed, input logic [3:0] lim, input int max_tries,
                            output int cycles, output logic [7:0] res, output logic to);
        logic [15:0] s;
        logic [7:0]  c;
        logic        ok0, ok1;
        s = seed; cycles = 0; res = '0; to = 1'b0;
        for (int t = 0; t < max_tries; t++) begin
            s = ref_step(s);
            cycles++;
            c = ref_cand(s);
            ok0 = (lim == 0) || (c[3:0] < lim);
            ok1 = (lim == 0) || (c[7:4] < lim);
            if (ok0 && ok1) begin
                res = c;
                return;
            end
            if (t == max_tries - 1) begin
                res = {ok1 ? c[7:4] : 4'h0, ok0 ? c[3:0] : 4'h0};
                to  = 1'b1;
            end
        end
    endtask

    // Loads a seed, pulses req for one cycle, then waits (bounded) for valid.
    task automatic applyStimulus(input int sel, input logic [15:0] seed, input logic [3:0] lim,
                                 output int busy_cnt, output logic seen, output logic [7:0] res,
                                 output logic to, output logic busy_at_valid);
        seed_load[sel] = 1'b1;
        seed_in[sel]   = seed;
        @(posedge clk); @(negedge clk);
        seed_load[sel] = 1'b0;
        req[sel]       = 1'b1;
        limit[sel]     = lim;
        @(posedge clk); @(negedge clk);
        req[sel] = 1'b0;
        busy_cnt = 0; seen = 1'b0; res = '0; to = 1'b0; busy_at_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((sel == 1) ? valid1 : valid0) begin
                seen          = 1'b1;
                res           = (sel == 1) ? out1 : out0;
                to            = (sel == 1) ? timeout1 : timeout0;
                busy_at_valid = (sel == 1) ? busy1 : busy0;
                break;
            end
            if ((sel == 1) ? busy1 : busy0)
                busy_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] seq [3];
        logic [15:0] s;
        logic [7:0]  held_exp [3];
        logic [7:0]  res, mres;
        logic        seen, to, bav, mto;
        int          bc, mc, zero_hits, vcount, n;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            seed_load[k] = 1'b0; seed_in[k] = '0; req[k] = 1'b0; limit[k] = '0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", state0, 16'h0001);
        checkOutput("reset_out", out0, 8'h00);
        checkOutput("reset_valid", valid0, 1'b0);
        checkOutput("reset_busy", busy0, 1'b0);
        checkOutput("reset_timeout", timeout0, 1'b0);
        reset = 1'b0;

        seq[0] = 16'hB400; seq[1] = 16'h5A00; seq[2] = 16'h2D00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("seq%0d", i), state0, seq[i]);
        end

        zero_hits = 0;
        for (int i = 0; i < 65532; i++) begin
            @(negedge clk);
            if (state0 == 16'h0000)
                zero_hits++;
        end
        checkOutput("period", state0, 16'h0001);
        checkOutput("never_zero", zero_hits, 0);

        seed_load[0] = 1'b1; seed_in[0] = 16'h0000;
        @(negedge clk);
        seed_load[0] = 1'b0;
        checkOutput("zero_seed", state0, 16'h0001);

        // Unbounded: evaluated state is B452 -> ch1=1, ch0=C.
        applyStimulus(0, 16'h00A5, 4'd0, bc, seen, res, to, bav);
        checkOutput("unb_seen", seen, 1'b1);
        checkOutput("unb_out", res, 8'h1C);
        checkOutput("unb_busy_cycles", bc, 1);
        checkOutput("unb_timeout", to, 1'b0);
        checkOutput("unb_busy_at_valid", bav, 1'b0);
        checkOutput("unb_state", state0, 16'h5A29);
        @(negedge clk);
        checkOutput("unb_valid_pulse", valid0, 1'b0);

        ref_draw(16'h00FF, 4'd4, 64, mc, mres, mto);
        applyStimulus(0, 16'h00FF, 4'd4, bc, seen, res, to, bav);
        checkOutput("rej_seen", seen, 1'b1);
        checkOutput("rej_busy_cycles", bc, mc);
        checkOutput("rej_out", res, mres);
        checkOutput("rej_timeout", to, mto);
        checkOutput("rej_in_range", (res[3:0] < 4) && (res[7:4] < 4), 1'b1);
        @(negedge clk);
        checkOutput("rej_valid_pulse", valid0, 1'b0);

        // Four rejected candidates (10,08,04,02 low bytes); forced result is zero.
        applyStimulus(1, 16'h0020, 4'd1, bc, seen, res, to, bav);
        checkOutput("to1_seen", seen, 1'b1);
        checkOutput("to1_busy_cycles", bc, 4);
        checkOutput("to1_out", res, 8'h00);
        checkOutput("to1_timeout", to, 1'b1);
        @(negedge clk);
        checkOutput("to1_timeout_pulse", timeout1, 1'b0);
        checkOutput("to1_valid_pulse", valid1, 1'b0);

        // Last candidate 00AB: ch0=1 kept, ch1=F rejected and zeroed.
        applyStimulus(1, 16'h0AB0, 4'd4, bc, seen, res, to, bav);
        checkOutput("to2_seen", seen, 1'b1);
        checkOutput("to2_busy_cycles", bc, 4);
        checkOutput("to2_out", res, 8'h01);
        checkOutput("to2_timeout", to, 1'b1);

        // Reset mid-draw: seed 00FF with limit 4 rejects its first candidates.
        seed_load[0] = 1'b1; seed_in[0] = 16'h00FF;
        @(negedge clk);
        seed_load[0] = 1'b0; req[0] = 1'b1; limit[0] = 4'd4;
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        checkOutput("mid_busy_before", busy0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid_busy", busy0, 1'b0);
        checkOutput("mid_state", state0, 16'h0001);
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid0) vcount++;
            @(negedge clk);
        end
        checkOutput("mid_no_valid", vcount, 0);

        // Extra req pulses while busy must not queue a second draw.
        ref_draw(16'h00FF, 4'd4, 64, mc, mres, mto);
        seed_load[0] = 1'b1; seed_in[0] = 16'h00FF;
        @(negedge clk);
        seed_load[0] = 1'b0; req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        vcount = 0;
        for (int i = 0; i < mc + 8; i++) begin
            if (i == 1) req[0] = 1'b1;
            if (i == 2) req[0] = 1'b0;
            if (valid0) vcount++;
            @(negedge clk);
        end
        checkOutput("busy_req_one_valid", vcount, 1);

        // Held req with no bound: results from states s1, s3, s5 every 2 cycles.
        s = 16'h1234;
        for (int k = 1; k <= 5; k++) begin
            s = ref_step(s);
            if (k % 2 == 1) held_exp[k/2] = ref_cand(s);
        end
        seed_load[0] = 1'b1; seed_in[0] = 16'h1234;
        @(negedge clk);
        seed_load[0] = 1'b0; req[0] = 1'b1; limit[0] = 4'd0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid0) begin
                if (n < 3) checkOutput($sformatf("held_out%0d", n), out0, held_exp[n]);
                n++;
            end
        end
        req[0] = 1'b0;
        checkOutput("held_count", n, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
